string_byte_serializer: RTL

//  Consumes packed Verilog string words (ASCII, MSB-first, NUL-padded on the left

---
 rtl/string_pkg.sv | 18 +
 rtl/string_lead_nul_cnt.sv | 37 +++
 rtl/string_byte_serializer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/string_pkg.sv
// -----------------------------------------------------------------------------
// string_pkg
//   Shared definitions for the string byte serializer slice.
//   CHAR_W  : width of one ASCII character
//   NUL     : padding character stripped from the front of each word
//   state_t : serializer FSM states
// -----------------------------------------------------------------------------
package string_pkg;

    localparam int          CHAR_W = 8;
    localparam logic [7:0]  NUL    = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : string_pkg

// File: rtl/string_lead_nul_cnt.sv
// -----------------------------------------------------------------------------
// string_lead_nul_cnt
//   Combinational priority encoder: counts the NUL characters at the front of a
//   packed string word, scanning from char 0 (the most significant byte).
//   Ports:
//     word_i  in   8*NCHARS            packed string, char 0 in the top byte
//     cnt_o   out  $clog2(NCHARS+1)    number of leading NUL characters
//                                      (NCHARS when the whole word is NUL)
// -----------------------------------------------------------------------------
module string_lead_nul_cnt
    import string_pkg::*;
#(
    parameter int NCHARS = 4,
    localparam int LZ_W  = $clog2(NCHARS + 1)
) (
    input  logic [CHAR_W*NCHARS-1:0] word_i,
    output logic [LZ_W-1:0]          cnt_o
);

    logic found;

    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NCHARS; k++) begin
            if (!found) begin
                if (word_i[CHAR_W*NCHARS-1-CHAR_W*k -: CHAR_W] == NUL) begin
                    // Every character up to and including k is NUL.
                    cnt_o = LZ_W'(k + 1);
                end else begin
                    found = 1'b1;
                end
            end
        end
    end

endmodule : string_lead_nul_cnt

// File: rtl/string_byte_serializer.sv
// -----------------------------------------------------------------------------
// string_byte_serializer
//   Accepts packed, left-NUL-padded ASCII string words and streams the
//   characters after the leading padding one byte per transfer, flagging the
//   final character of each word. All-NUL words produce no output and bump a
//   saturating drop counter.
//   Ports:
//     clk        in   1          rising-edge clock
//     rst_n      in   1          asynchronous active-low reset
//     in_valid   in   1          input word valid
//     in_ready   out  1          word can be accepted this cycle
//     in_data    in   8*NCHARS   packed string, char 0 = in_data[8*NCHARS-1 -: 8]
//     out_valid  out  1          out_data holds a character
//     out_ready  in   1          sink accepts the character this cycle
//     out_data   out  8          ASCII character
//     out_last   out  1          final character of the current word
//     busy       out  1          a word is being streamed
//     drop_cnt   out  CNT_W      all-NUL words received, saturating
// -----------------------------------------------------------------------------
module string_byte_serializer
    import string_pkg::*;
#(
    parameter int NCHARS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHAR_W*NCHARS-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHAR_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int WORD_W = CHAR_W * NCHARS;
    localparam int LZ_W   = $clog2(NCHARS + 1);

    localparam logic [LZ_W-1:0] ALL_NUL  = LZ_W'(NCHARS);
    localparam logic [LZ_W-1:0] LAST_IDX = LZ_W'(NCHARS - 1);

    // Select character i of a packed word (char 0 is the top byte).
    function automatic logic [CHAR_W-1:0] get_char(
        input logic [WORD_W-1:0] w,
        input logic [LZ_W-1:0]   i
    );
        logic [CHAR_W-1:0] c;
        c = '0;
        for (int k = 0; k < NCHARS; k++) begin
            if (i == LZ_W'(k)) begin
                c = w[WORD_W-1-CHAR_W*k -: CHAR_W];
            end
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [LZ_W-1:0]    idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [CHAR_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [LZ_W-1:0]    lz;
    logic               accept;
    logic [LZ_W-1:0]    idx_nxt;

    string_lead_nul_cnt #(
        .NCHARS (NCHARS)
    ) u_lead_nul_cnt (
        .word_i (in_data),
        .cnt_o  (lz)
    );

    // A new word may enter while idle, or in the same cycle the final
    // character of the current word is taken, so streams run without bubbles.
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == SEND) && out_valid_q && out_last_q && out_ready);
    assign accept   = in_valid && in_ready;
    assign idx_nxt  = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        drop_cnt_d  = drop_cnt_q;

        if (accept) begin
            word_d = in_data;
            idx_d  = lz;
            if (lz == ALL_NUL) begin
                // Nothing to send; also covers an all-NUL word in the restart cycle.
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (drop_cnt_q != {CNT_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end else begin
                state_d     = SEND;
                out_valid_d = 1'b1;
                out_data_d  = get_char(in_data, lz);
                out_last_d  = (lz == LAST_IDX);
            end
        end else if ((state_q == SEND) && out_ready) begin
            if (!out_last_q) begin
                idx_d      = idx_nxt;
                out_data_d = get_char(word_q, idx_nxt);
                out_last_d = (idx_nxt == LAST_IDX);
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
        // With out_ready low in SEND every output register simply holds.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == SEND);
    assign drop_cnt  = drop_cnt_q;

endmodule : string_byte_serializer
